pid_sched_ctrl: RTL and testbench



---
 rtl/pid_sched_pkg.sv | 28 ++
 rtl/pid_sched_ctrl_sat_counter.sv | 24 ++
 rtl/pid_sched_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pid_sched_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_sched_pkg.sv
// Shared types and PID constants for the PID-FIFO scheduler.
package pid_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        TOK,
        AES_RUN,
        HS,
        ERR
    } state_t;

    // USB PID type codes (low nibble of the PID byte)
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;

    // A PID byte is well formed when its upper nibble is the complement of the lower one.
    function automatic logic pid_check(input logic [7:0] pid);
        return (pid[7:4] == ~pid[3:0]);
    endfunction

endpackage

// File: rtl/pid_sched_ctrl_sat_counter.sv
// Saturating up-counter: stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count increment requests, holding once the counter is full.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pid_sched_ctrl.sv
// Drains the packet-order PID FIFO one entry at a time and dispatches each PID
// to the token handler, the AES encrypt engine or the handshake responder.
module pid_sched_ctrl
    import pid_sched_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TMO_W   = 10,
    parameter int TMO_MAX = 1000
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             pid_empty,
    input  logic [7:0]       pid_rdata,
    output logic             pid_renable,
    output logic             tok_valid,
    output logic [3:0]       tok_pid,
    input  logic             tok_ready,
    output logic             aes_start,
    input  logic             aes_done,
    output logic             hs_valid,
    output logic             hs_ack,
    input  logic             hs_ready,
    output logic             toggle_err,
    output logic             pid_err,
    output logic             tmo_err,
    output logic             busy,
    output logic [CNT_W-1:0] data_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Last count value before the timeout fires on the following edge.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t           state_q;
    logic [7:0]       pid_q;
    logic             want_data1_q;   // 0: next DATA PID should be DATA0
    logic [TMO_W-1:0] tmo_q;
    logic             pid_renable_q;
    logic             tok_valid_q;
    logic [3:0]       tok_pid_q;
    logic             aes_start_q;
    logic             hs_valid_q;
    logic             hs_ack_q;
    logic             toggle_err_q;
    logic             pid_err_q;
    logic             tmo_err_q;
    logic [CNT_W-1:0] data_cnt_q;

    logic             is_tok;
    logic             is_data;
    logic             is_hs;
    logic             pid_err_d;
    logic             toggle_err_d;
    logic             tmo_err_d;
    logic             err_inc_d;

    // Classify the latched PID and detect the error events of this cycle.
    always_comb begin
        is_tok       = (pid_q[3:0] == PID_OUT) || (pid_q[3:0] == PID_IN) ||
                       (pid_q[3:0] == PID_SETUP);
        is_data      = (pid_q[3:0] == PID_DATA0) || (pid_q[3:0] == PID_DATA1);
        is_hs        = (pid_q[3:0] == PID_ACK) || (pid_q[3:0] == PID_NAK);
        pid_err_d    = (state_q == DECODE) &&
                       (!pid_check(pid_q) || !(is_tok || is_data || is_hs));
        toggle_err_d = (state_q == DECODE) && pid_check(pid_q) && is_data &&
                       ((pid_q[3:0] == PID_DATA1) != want_data1_q);
        tmo_err_d    = (state_q == AES_RUN) && !aes_done && (tmo_q == TMO_LAST);
        // Error pulses are mutually exclusive in time, so a single increment suffices.
        err_inc_d    = pid_err_d | toggle_err_d | tmo_err_d;
    end

    // Scheduler FSM with registered outputs, toggle tracking and the job timeout.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            pid_q         <= '0;
            want_data1_q  <= 1'b0;
            tmo_q         <= '0;
            pid_renable_q <= 1'b0;
            tok_valid_q   <= 1'b0;
            tok_pid_q     <= '0;
            aes_start_q   <= 1'b0;
            hs_valid_q    <= 1'b0;
            hs_ack_q      <= 1'b0;
            toggle_err_q  <= 1'b0;
            pid_err_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
            data_cnt_q    <= '0;
        end else begin
            pid_renable_q <= 1'b0;
            aes_start_q   <= 1'b0;
            toggle_err_q  <= 1'b0;
            pid_err_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!pid_empty) begin
                        pid_renable_q <= 1'b1;
                        pid_q         <= pid_rdata;
                        state_q       <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= DECODE;
                end
                DECODE: begin
                    if (pid_err_d) begin
                        pid_err_q <= 1'b1;
                        state_q   <= ERR;
                    end else if (is_tok) begin
                        tok_valid_q <= 1'b1;
                        tok_pid_q   <= pid_q[3:0];
                        if (pid_q[3:0] == PID_SETUP) begin
                            want_data1_q <= 1'b0;
                        end
                        state_q <= TOK;
                    end else if (is_data) begin
                        aes_start_q  <= 1'b1;
                        toggle_err_q <= toggle_err_d;
                        want_data1_q <= (pid_q[3:0] == PID_DATA0);
                        data_cnt_q   <= data_cnt_q + 1'b1;
                        tmo_q        <= '0;
                        state_q      <= AES_RUN;
                    end else begin
                        hs_valid_q <= 1'b1;
                        hs_ack_q   <= (pid_q[3:0] == PID_ACK);
                        state_q    <= HS;
                    end
                end
                TOK: begin
                    if (tok_ready) begin
                        tok_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                AES_RUN: begin
                    if (aes_done) begin
                        state_q <= IDLE;
                    end else if (tmo_err_d) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                HS: begin
                    if (hs_ready) begin
                        hs_valid_q <= 1'b0;
                        hs_ack_q   <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .n_rst(n_rst),
        .inc_i(err_inc_d),
        .cnt_o(err_cnt)
    );

    assign pid_renable = pid_renable_q;
    assign tok_valid   = tok_valid_q;
    assign tok_pid     = tok_pid_q;
    assign aes_start   = aes_start_q;
    assign hs_valid    = hs_valid_q;
    assign hs_ack      = hs_ack_q;
    assign toggle_err  = toggle_err_q;
    assign pid_err     = pid_err_q;
    assign tmo_err     = tmo_err_q;
    assign busy        = (state_q != IDLE);
    assign data_cnt    = data_cnt_q;

endmodule

// File: tb/tb_pid_sched_ctrl.sv
// Bench for pid_sched_ctrl: PID FIFO and AES/handshake partners, a packet-level
// model that predicts the dispatch sequence, and directed scenarios.
module tb_pid_sched_ctrl;

    localparam int CNT_W   = 16;
    localparam int TMO_W   = 10;
    localparam int TMO_MAX = 1000;

    localparam int EV_TOK = 0, EV_AES = 1, EV_HS = 2, EV_TOG = 3, EV_PIDERR = 4, EV_TMO = 5;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             pid_empty = 1'b1;
    logic [7:0]       pid_rdata = 8'h00;
    logic             pid_renable;
    logic             tok_valid;
    logic [3:0]       tok_pid;
    logic             tok_ready = 1'b1;
    logic             aes_start;
    logic             aes_done = 1'b0;
    logic             hs_valid;
    logic             hs_ack;
    logic             hs_ready = 1'b1;
    logic             toggle_err;
    logic             pid_err;
    logic             tmo_err;
    logic             busy;
    logic [CNT_W-1:0] data_cnt;
    logic [CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    pid_sched_ctrl #(
        .CNT_W  (CNT_W),
        .TMO_W  (TMO_W),
        .TMO_MAX(TMO_MAX)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .pid_empty  (pid_empty),
        .pid_rdata  (pid_rdata),
        .pid_renable(pid_renable),
        .tok_valid  (tok_valid),
        .tok_pid    (tok_pid),
        .tok_ready  (tok_ready),
        .aes_start  (aes_start),
        .aes_done   (aes_done),
        .hs_valid   (hs_valid),
        .hs_ack     (hs_ack),
        .hs_ready   (hs_ready),
        .toggle_err (toggle_err),
        .pid_err    (pid_err),
        .tmo_err    (tmo_err),
        .busy       (busy),
        .data_cnt   (data_cnt),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        int         kind;
        logic [3:0] val;
    } ev_t;

    int         total = 0;
    int         bad = 0;
    ev_t        expq[$];
    logic [7:0] fifo[$];
    logic       m_want1 = 1'b0;   // model: next DATA PID should be DATA1
    int         exp_data = 0;
    int         exp_err = 0;
    int         aes_mode = 1;     // 1: AES answers after aes_lat cycles, 0: never
    int         aes_lat = 20;
    int         cyc = 0;
    int         renable_cnt = 0;
    int         aes_cnt = 0;
    int         tog_cnt = 0;
    int         start_cyc = 0;
    int         tmo_cyc = 0;
    logic       last_hs_ack = 1'b0;
    logic       prev_tok = 1'b0;
    logic [3:0] prev_tok_pid = 4'h0;
    logic       prev_hs = 1'b0;
    logic       prev_hs_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add_ev(input int kind, input logic [3:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        expq.push_back(e);
    endtask

    // Consume the oldest predicted event; it must be the one the DUT just produced.
    task automatic expect_ev(input int kind, input logic [3:0] val);
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d val=%0h, none predicted", kind, val);
        end else if (expq[0].kind != kind || expq[0].val != val) begin
            bad++;
            $display("FAIL event: got kind=%0d val=%0h want kind=%0d val=%0h",
                     kind, val, expq[0].kind, expq[0].val);
        end else begin
            void'(expq.pop_front());
        end
    endtask

    // A held request must match the oldest predicted event without consuming it.
    task automatic peek_ev(input int kind, input logic [3:0] val);
        total++;
        if (expq.size() == 0 || expq[0].kind != kind || expq[0].val != val) begin
            bad++;
            $display("FAIL held request: got kind=%0d val=%0h, not the next predicted event",
                     kind, val);
        end
    endtask

    // Packet-level model: what popping byte b must eventually cause.
    task automatic predict(input logic [7:0] b);
        logic [3:0] lo;
        lo = b[3:0];
        if (b[7:4] != ~lo) begin
            add_ev(EV_PIDERR, 4'h0);
        end else if (lo == 4'h1 || lo == 4'h9) begin
            add_ev(EV_TOK, lo);
        end else if (lo == 4'hD) begin
            add_ev(EV_TOK, lo);
            m_want1 = 1'b0;
        end else if (lo == 4'h3 || lo == 4'hB) begin
            add_ev(EV_AES, 4'h0);
            if ((lo == 4'hB) != m_want1) add_ev(EV_TOG, 4'h0);
            m_want1 = (lo == 4'h3);
            if (aes_mode == 0) add_ev(EV_TMO, 4'h0);
        end else if (lo == 4'h2) begin
            add_ev(EV_HS, 4'h1);
        end else if (lo == 4'hA) begin
            add_ev(EV_HS, 4'h0);
        end else begin
            add_ev(EV_PIDERR, 4'h0);
        end
    endtask

    task automatic drive_fifo();
        pid_empty = (fifo.size() == 0);
        pid_rdata = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive_fifo();
    endtask

    // Compare process: every cycle, match DUT activity against the model and keep the FIFO.
    always @(negedge clk) begin
        logic [7:0] b;
        cyc++;
        if (!n_rst) begin
            prev_tok = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            if (prev_tok && !tok_valid) expect_ev(EV_TOK, prev_tok_pid);
            if (prev_hs && !hs_valid) expect_ev(EV_HS, {3'b000, prev_hs_ack});
            if (tok_valid) peek_ev(EV_TOK, tok_pid);
            if (hs_valid) begin
                peek_ev(EV_HS, {3'b000, hs_ack});
                last_hs_ack = hs_ack;
            end
            if (aes_start) begin
                expect_ev(EV_AES, 4'h0);
                exp_data++;
                aes_cnt++;
                start_cyc = cyc;
            end
            if (toggle_err) begin
                expect_ev(EV_TOG, 4'h0);
                exp_err++;
                tog_cnt++;
            end
            if (pid_err) begin
                expect_ev(EV_PIDERR, 4'h0);
                exp_err++;
            end
            if (tmo_err) begin
                expect_ev(EV_TMO, 4'h0);
                exp_err++;
                tmo_cyc = cyc;
            end
            chk("data_cnt", 32'(data_cnt), 32'(exp_data));
            chk("err_cnt", 32'(err_cnt), 32'(exp_err));
            prev_tok     = tok_valid;
            prev_tok_pid = tok_pid;
            prev_hs      = hs_valid;
            prev_hs_ack  = hs_ack;
            if (pid_renable) begin
                renable_cnt++;
                chk("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
                if (fifo.size() != 0) begin
                    b = fifo.pop_front();
                    predict(b);
                    drive_fifo();
                end
            end
        end
    end

    // AES core stand-in: answers each start after aes_lat cycles unless disabled.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst && aes_start && aes_mode == 1) begin
                repeat (aes_lat) @(negedge clk);
                aes_done = 1'b1;
                @(negedge clk);
                aes_done = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (fifo.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: scheduler did not go idle within %0d cycles", name, budget);
        end
        @(negedge clk);
    endtask

    initial begin
        int base_ren;
        int base_aes;
        int base_tog;
        int n;

        // Reset and idle state
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {23'd0, pid_renable, tok_valid, aes_start, hs_valid, hs_ack,
                              toggle_err, pid_err, tmo_err, busy}, 32'd0);
        chk("reset_data_cnt", 32'(data_cnt), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);

        // OUT token held by a stalled handler
        tok_ready = 1'b0;
        base_ren  = renable_cnt;
        push(8'hE1);
        n = 0;
        while (!tok_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tok_seen", 32'(tok_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tok_held_valid", 32'(tok_valid), 32'd1);
            chk("tok_held_pid", 32'(tok_pid), 32'h1);
        end
        tok_ready = 1'b1;
        @(negedge clk);
        chk("tok_dropped", 32'(tok_valid), 32'd0);
        chk("tok_busy_clear", 32'(busy), 32'd0);
        chk("tok_one_pop", 32'(renable_cnt - base_ren), 32'd1);

        // Three DATA packets with correct toggling
        aes_mode = 1;
        aes_lat  = 20;
        base_aes = aes_cnt;
        base_tog = tog_cnt;
        push(8'hC3);
        push(8'h4B);
        push(8'hC3);
        wait_idle(400, "data_run");
        chk("data_starts", 32'(aes_cnt - base_aes), 32'd3);
        chk("data_cnt_3", 32'(data_cnt), 32'd3);
        chk("data_no_toggle_err", 32'(tog_cnt - base_tog), 32'd0);

        // SETUP resets the toggle, so DATA1 next is a toggle error but still encrypted
        base_aes = aes_cnt;
        base_tog = tog_cnt;
        push(8'h2D);
        push(8'h4B);
        wait_idle(400, "setup_data1");
        chk("setup_toggle_err", 32'(tog_cnt - base_tog), 32'd1);
        chk("setup_aes_start", 32'(aes_cnt - base_aes), 32'd1);
        chk("setup_err_cnt", 32'(err_cnt), 32'd1);

        // AES never answers: timeout, then the queued ACK is served
        aes_mode = 0;
        push(8'hC3);
        push(8'hD2);
        wait_idle(3000, "timeout");
        chk("tmo_latency", 32'(tmo_cyc - start_cyc), 32'(TMO_MAX));
        chk("tmo_err_cnt", 32'(err_cnt), 32'd2);
        chk("tmo_then_ack", 32'(last_hs_ack), 32'd1);

        // Malformed PID is dropped, following NAK is served
        aes_mode = 1;
        base_aes = aes_cnt;
        push(8'hFF);
        push(8'h5A);
        wait_idle(200, "bad_pid");
        chk("bad_pid_err_cnt", 32'(err_cnt), 32'd3);
        chk("bad_pid_nak", 32'(last_hs_ack), 32'd0);
        chk("bad_pid_no_aes", 32'(aes_cnt - base_aes), 32'd0);

        // Reset in the middle of an AES job with two PIDs still queued
        aes_mode = 0;
        push(8'hC3);
        push(8'hE1);
        push(8'h69);
        n = 0;
        while (!aes_start && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("mid_job_started", 32'(aes_start), 32'd1);
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        expq.delete();
        m_want1  = 1'b0;
        exp_data = 0;
        exp_err  = 0;
        @(negedge clk);
        chk("midrst_outputs", {23'd0, pid_renable, tok_valid, aes_start, hs_valid, hs_ack,
                               toggle_err, pid_err, tmo_err, busy}, 32'd0);
        chk("midrst_data_cnt", 32'(data_cnt), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst_fifo_left", 32'(fifo.size()), 32'd2);
        n_rst    = 1'b1;
        base_ren = renable_cnt;
        wait_idle(200, "after_reset");
        chk("resume_pops", 32'(renable_cnt - base_ren), 32'd2);
        chk("resume_data_cnt", 32'(data_cnt), 32'd0);
        chk("resume_err_cnt", 32'(err_cnt), 32'd0);
        chk("all_events_seen", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
